tri_wave_mon: RTL and testbench
===============================

// Module: tri_wave_mon
// PURPOSE
//  Waveform monitor sitting directly downstream of the triangle generator; consumes its 9-bit sample stream.
//  Classifies each sample step as rising / flat-top / falling / flat-bottom, and reports segment lengths,
//  peak/floor levels and full-cycle period. Flags illegal slope steps (|delta|>1).
//  Used as on-chip self-check and as the measurement source for generator bring-up.
// PARAMETERS
//  DW   9   sample width (matches generator output)
//  CW   16  width of segment-length and period counters (saturating)
// PORTS
//  clk         in   1    clock, all logic on posedge
//  res         in   1    synchronous, active-high reset
//  d_in        in   DW   sample, new value every clk
//  seg_vld     out  1    seg/peak/floor meaningful (first classified step seen)
//  seg         out  2    current segment: 0 RISE, 1 HIGH, 2 FALL, 3 LOW
//  seg_chg     out  1    1-cycle pulse: segment just changed
//  seg_len     out  CW   length (steps) of segment that just ended; updated only with seg_chg
//  peak        out  DW   last value reached when leaving RISE
//  floor       out  DW   last value reached when leaving FALL
//  period      out  CW   steps between two consecutive RISE entries; updated only with period_vld
//  period_vld  out  1    1-cycle pulse on RISE entry when a previous RISE entry exists
//  step_err    out  1    sticky: some |d_in - d_prev| > 1; cleared only by res
// BEHAVIOUR
//  - Reset (res=1 at posedge): all outputs 0, internal state INIT, d_prev=0, counters 0, period history discarded.
//    Applies identically mid-operation.
//  - Internal FSM: INIT, RISE, HIGH, FALL, LOW. INIT: capture d_prev<=d_in, go ARM-free to classify next cycle.
//  - Step delta = d_in - d_prev, DW+1 bit signed. Class: delta>0 RISE; delta<0 FALL;
//    delta==0 HIGH if current state RISE/HIGH, LOW if FALL/LOW; first step after INIT with delta==0 is LOW.
//  - Every non-INIT cycle: d_prev<=d_in; state<=class. seg/seg_vld are registered: 1 cycle latency from sample.
//  - Same class: len_cnt+1 (saturate at 2^CW-1). Class change: seg_chg=1, seg_len<=len_cnt, len_cnt<=1.
//    First classification after INIT: len_cnt<=1, seg_vld<=1, no seg_chg.
//  - Leaving RISE (any new class): peak<=d_prev. Leaving FALL: floor<=d_prev.
//  - Direct reversal RISE->FALL or FALL->RISE legal: normal seg_chg, peak/floor update.
//  - Period: per_cnt counts steps since last RISE entry (saturating).
//    RISE entry with history: period<=per_cnt, period_vld=1, per_cnt<=1. First RISE entry: arm history, per_cnt<=1.
//  - step_err<=1 when |delta|>1 in any non-INIT cycle. Classification proceeds normally.
//  - Simultaneous RISE entry and seg_chg: both pulses in same cycle.
// STRUCTURE
//  - Shared package tri_pkg: SEG_RISE/HIGH/FALL/LOW 2-bit constants, default DW.
//    Same encoding as the generator's state numbering.
//  - Sub-module sat_cnt (#(CW): clr-to-1, inc, saturate), instanced twice: segment length, period.
//  - Rest (FSM, delta/classify, peak/floor/err registers) in tri_wave_mon.
// TESTING
//  1 res=1 3 cycles with d_in=5 -> all outputs 0; release, d_in const 5 -> seg_vld=1, seg=LOW, no seg_chg.
//  2 ramp 0..300 step 1, then hold 300 for 200 cycles -> seg=RISE; at first hold step seg_chg, seg_len=300,
//    peak=300, seg=HIGH.
//  3 two full generator cycles (rise 300, hold 201, fall 300, hold 201) -> floor=0, period_vld at second
//    RISE entry with period=1002.
//  4 sequence 10,11,12,11,10 -> seg_chg to FALL with seg_len=2, peak=12, step_err=0;
//    then 10->13 -> step_err=1, stays 1.
//  5 CW=4, hold value 40 cycles -> seg_len on next change = 15 (saturated).
//  6 res pulse mid-FALL -> outputs 0 next cycle, step_err cleared; first RISE entry after has no period_vld.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared constants for the triangle generator and its waveform monitor.
// Segment encoding matches the generator's state numbering.
package tri_pkg;

  localparam int unsigned DEF_DW = 9;

  localparam logic [1:0] SEG_RISE = 2'd0;
  localparam logic [1:0] SEG_HIGH = 2'd1;
  localparam logic [1:0] SEG_FALL = 2'd2;
  localparam logic [1:0] SEG_LOW  = 2'd3;

  // Monitor FSM: classified states carry the segment code in the low bits.
  localparam logic [2:0] ST_RISE = {1'b0, SEG_RISE};
  localparam logic [2:0] ST_HIGH = {1'b0, SEG_HIGH};
  localparam logic [2:0] ST_FALL = {1'b0, SEG_FALL};
  localparam logic [2:0] ST_LOW  = {1'b0, SEG_LOW};
  localparam logic [2:0] ST_INIT = 3'd4;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: clear loads 1, increment stops at all-ones.
module sat_cnt #(
  parameter int unsigned CW = 16
) (
  input  logic          i_clk,
  input  logic          i_res,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [CW-1:0] o_q
);

  localparam logic [CW-1:0] One = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= One;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + One;
    end
  end

  assign o_q = r_cnt;

endmodule

// File: rtl/tri_wave_mon.sv
// Triangle waveform monitor: classifies sample steps into segments and measures
// segment lengths, peak/floor levels, full-cycle period and illegal slope steps.
module tri_wave_mon
  import tri_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          res,
  input  logic [DW-1:0] d_in,
  output logic          seg_vld,
  output logic [1:0]    seg,
  output logic          seg_chg,
  output logic [CW-1:0] seg_len,
  output logic [DW-1:0] peak,
  output logic [DW-1:0] floor,
  output logic [CW-1:0] period,
  output logic          period_vld,
  output logic          step_err
);

  localparam logic signed [DW:0] W_ONE  = {{DW{1'b0}}, 1'b1};
  localparam logic signed [DW:0] W_MONE = '1;

  logic [2:0]    r_state;
  logic          r_primed;
  logic          r_per_arm;
  logic [DW-1:0] r_d_prev;
  logic          r_seg_vld;
  logic [1:0]    r_seg;
  logic          r_seg_chg;
  logic [CW-1:0] r_seg_len;
  logic [DW-1:0] r_peak;
  logic [DW-1:0] r_floor;
  logic [CW-1:0] r_period;
  logic          r_period_vld;
  logic          r_step_err;

  logic signed [DW:0] w_delta;
  logic               w_big;
  logic [1:0]         w_cls;
  logic               w_classify;
  logic               w_first;
  logic               w_change;
  logic               w_same;
  logic               w_rise_entry;
  logic [CW-1:0]      w_len_q;
  logic [CW-1:0]      w_per_q;

  assign w_delta = signed'({1'b0, d_in}) - signed'({1'b0, r_d_prev});
  assign w_big   = (w_delta > W_ONE) || (w_delta < W_MONE);

  // Flat steps inherit the level (top/bottom) of the slope they follow; INIT counts as bottom.
  always_comb begin
    w_cls = SEG_LOW;
    if (w_delta > 0) begin
      w_cls = SEG_RISE;
    end else if (w_delta < 0) begin
      w_cls = SEG_FALL;
    end else if ((r_state == ST_RISE) || (r_state == ST_HIGH)) begin
      w_cls = SEG_HIGH;
    end
  end

  // INIT spends one cycle capturing d_prev, the next cycle is the first classification.
  assign w_first      = (r_state == ST_INIT) && r_primed;
  assign w_classify   = (r_state != ST_INIT) || r_primed;
  assign w_same       = w_classify && !w_first && (w_cls == r_state[1:0]);
  assign w_change     = w_classify && !w_first && (w_cls != r_state[1:0]);
  assign w_rise_entry = w_classify && (w_cls == SEG_RISE) &&
                        (w_first || (r_state[1:0] != SEG_RISE));

  sat_cnt #(
    .CW(CW)
  ) u_len_cnt (
    .i_clk(clk),
    .i_res(res),
    .i_clr(w_first || w_change),
    .i_inc(w_same),
    .o_q  (w_len_q)
  );

  sat_cnt #(
    .CW(CW)
  ) u_per_cnt (
    .i_clk(clk),
    .i_res(res),
    .i_clr(w_rise_entry),
    .i_inc(w_classify && !w_rise_entry),
    .o_q  (w_per_q)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      r_state      <= ST_INIT;
      r_primed     <= 1'b0;
      r_per_arm    <= 1'b0;
      r_d_prev     <= '0;
      r_seg_vld    <= 1'b0;
      r_seg        <= '0;
      r_seg_chg    <= 1'b0;
      r_seg_len    <= '0;
      r_peak       <= '0;
      r_floor      <= '0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_step_err   <= 1'b0;
    end else begin
      r_seg_chg    <= 1'b0;
      r_period_vld <= 1'b0;
      r_d_prev     <= d_in;
      if (r_state == ST_INIT) begin
        r_primed <= 1'b1;
      end
      if (w_classify) begin
        r_state   <= {1'b0, w_cls};
        r_seg     <= w_cls;
        r_seg_vld <= 1'b1;
        if (w_change) begin
          r_seg_chg <= 1'b1;
          r_seg_len <= w_len_q;
          if (r_state == ST_RISE) begin
            r_peak <= r_d_prev;
          end
          if (r_state == ST_FALL) begin
            r_floor <= r_d_prev;
          end
        end
        if (w_rise_entry) begin
          if (r_per_arm) begin
            r_period     <= w_per_q;
            r_period_vld <= 1'b1;
          end
          r_per_arm <= 1'b1;
        end
        if (w_big) begin
          r_step_err <= 1'b1;
        end
      end
    end
  end

  assign seg_vld    = r_seg_vld;
  assign seg        = r_seg;
  assign seg_chg    = r_seg_chg;
  assign seg_len    = r_seg_len;
  assign peak       = r_peak;
  assign floor      = r_floor;
  assign period     = r_period;
  assign period_vld = r_period_vld;
  assign step_err   = r_step_err;

endmodule

// File: tb/tb_tri_wave_mon.sv
// Directed bench for tri_wave_mon: a CW=16 instance plus a CW=4 instance for saturation.
module tb_tri_wave_mon;
  import tri_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [8:0] d_in = '0;

  logic        a_seg_vld, a_seg_chg, a_period_vld, a_step_err;
  logic [1:0]  a_seg;
  logic [15:0] a_seg_len, a_period;
  logic [8:0]  a_peak, a_floor;

  logic        b_seg_vld, b_seg_chg, b_period_vld, b_step_err;
  logic [1:0]  b_seg;
  logic [3:0]  b_seg_len, b_period;
  logic [8:0]  b_peak, b_floor;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  tri_wave_mon #(.DW(9), .CW(16)) u_dut (
    .clk(clk), .res(res), .d_in(d_in),
    .seg_vld(a_seg_vld), .seg(a_seg), .seg_chg(a_seg_chg), .seg_len(a_seg_len),
    .peak(a_peak), .floor(a_floor), .period(a_period), .period_vld(a_period_vld),
    .step_err(a_step_err)
  );

  tri_wave_mon #(.DW(9), .CW(4)) u_sat (
    .clk(clk), .res(res), .d_in(d_in),
    .seg_vld(b_seg_vld), .seg(b_seg), .seg_chg(b_seg_chg), .seg_len(b_seg_len),
    .peak(b_peak), .floor(b_floor), .period(b_period), .period_vld(b_period_vld),
    .step_err(b_step_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [8:0] v, input int n);
    res  = 1'b1;
    d_in = v;
    repeat (n) @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  task automatic step(input logic [8:0] v);
    d_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_vld"}, 32'(a_seg_vld), 0);
    check_eq({tag, "_seg"}, 32'(a_seg), 0);
    check_eq({tag, "_chg"}, 32'(a_seg_chg), 0);
    check_eq({tag, "_len"}, 32'(a_seg_len), 0);
    check_eq({tag, "_peak"}, 32'(a_peak), 0);
    check_eq({tag, "_floor"}, 32'(a_floor), 0);
    check_eq({tag, "_per"}, 32'(a_period), 0);
    check_eq({tag, "_pvld"}, 32'(a_period_vld), 0);
    check_eq({tag, "_err"}, 32'(a_step_err), 0);
  endtask

  initial begin
    // 1: reset, then constant input classifies as LOW
    do_reset(9'd5, 3);
    check_all_zero("t1_rst");
    step(9'd5);
    check_eq("t1_cap_vld", 32'(a_seg_vld), 0);
    step(9'd5);
    check_eq("t1_vld", 32'(a_seg_vld), 1);
    check_eq("t1_seg", 32'(a_seg), 32'(SEG_LOW));
    check_eq("t1_chg", 32'(a_seg_chg), 0);
    step(9'd5);
    check_eq("t1_chg2", 32'(a_seg_chg), 0);

    // 2: ramp to 300 then hold
    do_reset(9'd0, 2);
    step(9'd0);
    for (int i = 1; i <= 300; i++) step(9'(i));
    check_eq("t2_seg_rise", 32'(a_seg), 32'(SEG_RISE));
    check_eq("t2_chg_rise", 32'(a_seg_chg), 0);
    step(9'd300);
    check_eq("t2_chg", 32'(a_seg_chg), 1);
    check_eq("t2_len", 32'(a_seg_len), 300);
    check_eq("t2_peak", 32'(a_peak), 300);
    check_eq("t2_seg_high", 32'(a_seg), 32'(SEG_HIGH));

    // 3: two full generator cycles, period between RISE entries
    do_reset(9'd0, 2);
    step(9'd0);
    for (int c = 0; c < 2; c++) begin
      for (int i = 1; i <= 300; i++) begin
        step(9'(i));
        if (i == 1) begin
          check_eq("t3_pvld_entry", 32'(a_period_vld), (c == 1) ? 1 : 0);
          if (c == 1) begin
            check_eq("t3_period", 32'(a_period), 1002);
            check_eq("t3_low_len", 32'(a_seg_len), 201);
          end
        end
        if (i == 2) check_eq("t3_pvld_after", 32'(a_period_vld), 0);
      end
      repeat (201) step(9'd300);
      for (int i = 299; i >= 0; i--) begin
        step(9'(i));
        if (i == 299) begin
          check_eq("t3_high_len", 32'(a_seg_len), 201);
          check_eq("t3_peak", 32'(a_peak), 300);
        end
      end
      for (int h = 0; h < 201; h++) begin
        step(9'd0);
        if (h == 0) begin
          check_eq("t3_fall_len", 32'(a_seg_len), 300);
          check_eq("t3_floor", 32'(a_floor), 0);
          check_eq("t3_seg_low", 32'(a_seg), 32'(SEG_LOW));
        end
      end
    end
    step(9'd1);
    check_eq("t3_pvld_third", 32'(a_period_vld), 1);
    check_eq("t3_period_third", 32'(a_period), 1002);

    // 4: direct reversal and slope error
    do_reset(9'd10, 2);
    step(9'd10);
    step(9'd11);
    step(9'd12);
    step(9'd11);
    check_eq("t4_chg", 32'(a_seg_chg), 1);
    check_eq("t4_seg", 32'(a_seg), 32'(SEG_FALL));
    check_eq("t4_len", 32'(a_seg_len), 2);
    check_eq("t4_peak", 32'(a_peak), 12);
    check_eq("t4_err0", 32'(a_step_err), 0);
    step(9'd10);
    step(9'd13);
    check_eq("t4_err1", 32'(a_step_err), 1);
    check_eq("t4_floor", 32'(a_floor), 10);
    check_eq("t4_seg_rise", 32'(a_seg), 32'(SEG_RISE));
    step(9'd14);
    check_eq("t4_err_sticky", 32'(a_step_err), 1);

    // 5: length counter saturation on the CW=4 instance
    do_reset(9'd7, 2);
    step(9'd7);
    repeat (40) step(9'd7);
    step(9'd8);
    check_eq("t5_chg", 32'(b_seg_chg), 1);
    check_eq("t5_sat_len", 32'(b_seg_len), 15);
    check_eq("t5_wide_len", 32'(a_seg_len), 40);

    // 6: reset mid-FALL discards period history and error
    do_reset(9'd0, 2);
    step(9'd0);
    step(9'd1);
    step(9'd2);
    step(9'd5);
    step(9'd4);
    step(9'd3);
    check_eq("t6_err_set", 32'(a_step_err), 1);
    check_eq("t6_seg_fall", 32'(a_seg), 32'(SEG_FALL));
    res  = 1'b1;
    d_in = 9'd3;
    @(posedge clk);
    #1;
    check_all_zero("t6_rst");
    res = 1'b0;
    step(9'd3);
    step(9'd2);
    step(9'd3);
    check_eq("t6_seg_rise", 32'(a_seg), 32'(SEG_RISE));
    check_eq("t6_chg", 32'(a_seg_chg), 1);
    check_eq("t6_no_pvld", 32'(a_period_vld), 0);
    check_eq("t6_err_clr", 32'(a_step_err), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
